prog_launcher: RTL and testbench
================================

# prog_launcher

Host-side sequencer that drives the processor's `init`/`req` inputs and consumes its `ack` done flag, running `NUM_PROGS` programs back to back. It sits outside the processor top level, in the FPGA wrapper or the bench harness. For each program it measures the latency from the `req` pulse to `ack`, and it flags any program that fails to halt within `TIMEOUT` cycles.

## Interface
- `NUM_PROGS`, default 3: programs launched per `go`; range 1..4.
- `RST_CYCLES`, default 2: cycles `dut_init` is held high before the first `req`; minimum 1.
- `TIMEOUT`, default 16'd4000: maximum cycles allowed from `req` to `ack`; 16-bit.

Ports:
- `clk` in 1: clock, posedge only.
- `init` in 1: synchronous active-high reset.
- `go` in 1: start a run; sampled only in IDLE.
- `dut_ack` in 1: processor done flag, combinational on the processor side.
- `dut_init` out 1: processor reset.
- `dut_req` out 1: processor start pulse.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a run ends, whether it finished normally or timed out.
- `timeout` out 1: sticky error flag; cleared by `init` or by an accepted `go`.
- `prog_idx` out 2: index of the program currently running or last finished.
- `last_cycles` out 16: latency of the most recently completed program.
- `cycles_valid` out 1: one-cycle pulse when `last_cycles` updates.

## Operation
FSM states: IDLE, RST, REQ, WAIT_LOW, WAIT_ACK, FIN.
- **IDLE:** if `go` is high, clear `timeout` and `prog_idx`, load the reset counter with `RST_CYCLES`, and go to RST. Otherwise stay.
- **RST:** drive `dut_init`=1 and decrement the counter. When the counter reaches 1, go to REQ.
- **REQ:** drive `dut_req`=1 for exactly one cycle, clear the latency counter `cnt` to 0, and go to WAIT_LOW.
- **WAIT_LOW:** `cnt`++ each cycle. `ack` may still be high from the previous halt, so `dut_ack` high is ignored here. When `dut_ack`=0, go to WAIT_ACK.
- **WAIT_ACK:** `cnt`++ each cycle. When `dut_ack`=1, latch `last_cycles`=`cnt` (value before the increment) and pulse `cycles_valid`.
  - If `prog_idx`==`NUM_PROGS`-1, go to FIN.
  - Otherwise `prog_idx`++ and go to REQ. There is no re-reset between programs.
- **Timeout check (WAIT_LOW and WAIT_ACK):** if `cnt`==`TIMEOUT` and the exit condition for the state is not met, set `timeout`=1, leave `last_cycles` unchanged, and go to FIN.
- **FIN:** pulse `done`=1 for one cycle and return to IDLE. `prog_idx` holds its value.
- **`go` outside IDLE:** ignored. No queuing.
- **`cnt` arithmetic:** 16-bit. It never wraps, because the timeout check fires first; this requires `TIMEOUT` < 16'hFFFF.

## Timing
- **Reset values:** all outputs 0. The exception is `dut_init`, which is driven as (state==RST) OR `init`, so the processor is reset together with the host.
- **`init` mid-run:** next state is IDLE. `timeout`, `last_cycles` and `prog_idx` are cleared. No `done` pulse is emitted.
- **`go` to first `dut_req`:** `go` is sampled at edge 0, `dut_init` is high for `RST_CYCLES` cycles, and `dut_req` is high in the cycle after that.
- **Latency definition:** if `dut_req` is high in cycle t, `dut_ack` first returns low in cycle t+a (a≥1), and then is first high in cycle t+k with k>a, then `last_cycles`=k and `cycles_valid` is high in cycle t+k+1.
- **Between programs:** the next `dut_req` is in cycle t+k+1, the same cycle as `cycles_valid`.
- **End of run:** `done` is high in the cycle after the last `cycles_valid`, or in the cycle after the timeout is detected.
- **`dut_req` width:** never high for two consecutive cycles.
- **`dut_init` and `dut_req`:** never high in the same cycle.

## Test plan
- **Single normal run:** processor model holds ack low for 10 cycles after `req` and then high; `NUM_PROGS`=1. Expect `dut_init` high for 2 cycles, one `dut_req` pulse, `last_cycles`=11, `cycles_valid` then `done` on consecutive cycles, `timeout`=0.
- **Three programs back to back:** latencies 5, 20 and 7. Expect `last_cycles` sequence 5, 20, 7 with `prog_idx` 0, 1, 2. Expect exactly 3 `dut_req` pulses, each in the same cycle as the prior program's `cycles_valid`, and exactly one `done`.
- **Stale ack:** ack is held high for 3 cycles after `req`, then low, then high at k=9. Expect the stale high to be ignored and `last_cycles`=9.
- **Timeout:** ack never rises, with `TIMEOUT`=50. Expect `timeout`=1 and `done` 51 to 52 cycles after `req`, no `cycles_valid`, and the remaining programs skipped. A following `go` clears `timeout`.
- **Reset mid-run:** assert `init` during WAIT_ACK of program 1. Expect `dut_init`=1 that cycle, IDLE next, all outputs 0, and no `done` pulse.
- **`go` while busy:** pulse `go` during WAIT_ACK. Expect no effect: the `dut_req` count and `prog_idx` are unchanged versus a run without the extra pulse.

Source files
------------

// File: rtl/prog_launcher.sv
// Host-side sequencer that resets the processor, launches NUM_PROGS programs back to back,
// measures each program's req-to-ack latency and flags programs that never halt.
module prog_launcher #(
    parameter int          NUM_PROGS  = 3,
    parameter int          RST_CYCLES = 2,
    parameter logic [15:0] TIMEOUT    = 16'd4000
) (
    input  logic        clk,
    input  logic        init,
    input  logic        go,
    input  logic        dut_ack,
    output logic        dut_init,
    output logic        dut_req,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [1:0]  prog_idx,
    output logic [15:0] last_cycles,
    output logic        cycles_valid
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        REQ,
        WAIT_LOW,
        WAIT_ACK,
        FIN
    } LaunchState;

    localparam logic [1:0]  LAST_IDX = 2'(NUM_PROGS - 1);
    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES);

    LaunchState state;
    LaunchState nextState;

    logic [15:0] rstCnt;
    logic [15:0] cnt;
    logic        startRun;
    logic        latchCycles;
    logic        advanceProg;
    logic        setTimeout;

    // Next-state logic plus one-cycle control strobes for the datapath.
    always_comb begin
        nextState   = state;
        startRun    = 1'b0;
        latchCycles = 1'b0;
        advanceProg = 1'b0;
        setTimeout  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    startRun  = 1'b1;
                    nextState = RST;
                end
            end
            RST: begin
                if (rstCnt <= 16'd1) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                nextState = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A high ack here is left over from the previous halt.
                if (!dut_ack) begin
                    nextState = WAIT_ACK;
                end else if (cnt == TIMEOUT) begin
                    setTimeout = 1'b1;
                    nextState  = FIN;
                end
            end
            WAIT_ACK: begin
                if (dut_ack) begin
                    latchCycles = 1'b1;
                    if (prog_idx == LAST_IDX) begin
                        nextState = FIN;
                    end else begin
                        advanceProg = 1'b1;
                        nextState   = REQ;
                    end
                end else if (cnt == TIMEOUT) begin
                    setTimeout = 1'b1;
                    nextState  = FIN;
                end
            end
            FIN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register and datapath. cnt is 0 during the REQ cycle, so the value
    // seen in the cycle ack rises equals the number of cycles since req.
    always_ff @(posedge clk) begin
        if (init) begin
            state        <= IDLE;
            rstCnt       <= 16'd0;
            cnt          <= 16'd0;
            timeout      <= 1'b0;
            prog_idx     <= 2'd0;
            last_cycles  <= 16'd0;
            cycles_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= nextState;
            cycles_valid <= latchCycles;
            done         <= (state == FIN);

            if (startRun) begin
                timeout  <= 1'b0;
                prog_idx <= 2'd0;
                rstCnt   <= RST_LOAD;
            end else if (state == RST) begin
                rstCnt <= rstCnt - 16'd1;
            end

            if (nextState == REQ) begin
                cnt <= 16'd0;
            end else if (state == REQ || state == WAIT_LOW || state == WAIT_ACK) begin
                cnt <= cnt + 16'd1;
            end

            if (latchCycles) begin
                last_cycles <= cnt;
            end
            if (advanceProg) begin
                prog_idx <= prog_idx + 2'd1;
            end
            if (setTimeout) begin
                timeout <= 1'b1;
            end
        end
    end

    assign dut_init = (state == RST) || init;
    assign dut_req  = (state == REQ);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: a processor model answers each req with a
// per-program ack profile, and a scoreboard queue holds the expected latencies.
module tb_prog_launcher;

    localparam int          NP  = 3;
    localparam int          RC  = 2;
    localparam logic [15:0] TO  = 16'd50;

    logic        clk = 1'b0;
    logic        init;
    logic        go;
    logic        dut_ack;
    logic        dut_init;
    logic        dut_req;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [1:0]  prog_idx;
    logic [15:0] last_cycles;
    logic        cycles_valid;

    prog_launcher #(
        .NUM_PROGS  (NP),
        .RST_CYCLES (RC),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .init         (init),
        .go           (go),
        .dut_ack      (dut_ack),
        .dut_init     (dut_init),
        .dut_req      (dut_req),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .prog_idx     (prog_idx),
        .last_cycles  (last_cycles),
        .cycles_valid (cycles_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cycles;
        logic        nextReq;
    } ExpEntry;

    ExpEntry expQ[$];
    int      idxQ[$];

    int passCount  = 0;
    int checkCount = 0;

    // Per-program ack profile: ack high for staleLen cycles after req, then low,
    // then high from cycle ackAt onward (ackAt 0 means the program never halts).
    int staleLen[NP];
    int ackAt[NP];

    int cycleNum = 0;
    int rel = -1;
    int progNum = 0;
    int reqInRun = 0;
    int reqCount = 0;
    int validCount = 0;
    int doneCount = 0;
    int initCycles = 0;
    int goCycle = 0;
    int firstReqCycle = -1;
    int lastReqCycle = 0;
    int validCycle = 0;
    int doneCycle = 0;
    int overlapErr = 0;
    int doubleReqErr = 0;
    int unexpectedReq = 0;
    int unexpectedValid = 0;
    logic prevReq = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    always @(posedge clk) cycleNum++;

    // Processor model and output monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        ExpEntry e;
        if (dut_init && dut_req) overlapErr++;
        if (dut_req && prevReq) doubleReqErr++;
        prevReq = dut_req;
        if (dut_init) initCycles++;

        if (dut_req) begin
            reqCount++;
            lastReqCycle = cycleNum;
            if (firstReqCycle < 0) firstReqCycle = cycleNum;
            if (idxQ.size() > 0) checkOutput("reqProgIdx", 32'(prog_idx), 32'(idxQ.pop_front()));
            else unexpectedReq++;
            progNum = reqInRun;
            reqInRun++;
            rel = 0;
        end else if (rel >= 0) begin
            rel++;
        end

        if (dut_init) begin
            dut_ack = 1'b0;
            rel = -1;
        end else if (rel >= 1 && progNum < NP) begin
            dut_ack = (rel <= staleLen[progNum]) || (ackAt[progNum] != 0 && rel >= ackAt[progNum]);
        end

        if (cycles_valid) begin
            validCount++;
            validCycle = cycleNum;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("lastCycles", 32'(last_cycles), 32'(e.cycles));
                checkOutput("reqWithValid", 32'(dut_req), 32'(e.nextReq));
            end else begin
                unexpectedValid++;
            end
        end

        if (done) begin
            doneCount++;
            doneCycle = cycleNum;
        end
    end

    task automatic setProfile(input int s0, input int k0, input int s1, input int k1, input int s2, input int k2);
        staleLen[0] = s0; ackAt[0] = k0;
        staleLen[1] = s1; ackAt[1] = k1;
        staleLen[2] = s2; ackAt[2] = k2;
    endtask

    task automatic clearRunStats();
        reqCount = 0;
        validCount = 0;
        doneCount = 0;
        initCycles = 0;
        reqInRun = 0;
        firstReqCycle = -1;
    endtask

    // Launch one run with the current profile and check its full outcome.
    task automatic applyStimulus(input string name, input bit extraGo);
        int expReqs = 0;
        int expValids = 0;
        int expIdx = 0;
        bit expTo = 1'b0;
        int d;
        ExpEntry e;
        expQ.delete();
        idxQ.delete();
        for (int i = 0; i < NP; i++) begin
            if (!expTo) begin
                idxQ.push_back(i);
                expReqs++;
                expIdx = i;
                if (ackAt[i] == 0) begin
                    expTo = 1'b1;
                end else begin
                    e.cycles  = 16'(ackAt[i]);
                    e.nextReq = (i < NP - 1);
                    expQ.push_back(e);
                    expValids++;
                end
            end
        end
        clearRunStats();

        @(negedge clk);
        go = 1'b1;
        goCycle = cycleNum;
        @(negedge clk);
        go = 1'b0;
        checkOutput({name, ".timeoutClearedOnGo"}, 32'(timeout), 0);
        checkOutput({name, ".busyAfterGo"}, 32'(busy), 1);

        if (extraGo) begin
            for (int i = 0; i < 500 && reqCount < 2; i++) @(posedge clk);
            repeat (3) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end

        for (int i = 0; i < 3000 && doneCount == 0; i++) @(posedge clk);
        checkOutput({name, ".doneSeen"}, 32'(doneCount != 0), 1);
        repeat (5) @(negedge clk);

        checkOutput({name, ".doneCount"}, 32'(doneCount), 1);
        checkOutput({name, ".reqCount"}, 32'(reqCount), 32'(expReqs));
        checkOutput({name, ".validCount"}, 32'(validCount), 32'(expValids));
        checkOutput({name, ".initCycles"}, 32'(initCycles), 32'(RC));
        checkOutput({name, ".goToReq"}, 32'(firstReqCycle - goCycle), 32'(RC + 1));
        checkOutput({name, ".timeoutFlag"}, 32'(timeout), 32'(expTo));
        checkOutput({name, ".progIdxHold"}, 32'(prog_idx), 32'(expIdx));
        checkOutput({name, ".busyIdle"}, 32'(busy), 0);
        checkOutput({name, ".scoreboardDrained"}, 32'(expQ.size() + idxQ.size()), 0);
        if (expTo) begin
            d = doneCycle - lastReqCycle;
            checkOutput({name, ".doneAfterTimeout"}, 32'(d >= 51 && d <= 52), 1);
        end else begin
            checkOutput({name, ".doneAfterValid"}, 32'(doneCycle - validCycle), 1);
        end
    endtask

    initial begin
        init = 1'b1;
        go = 1'b0;
        dut_ack = 1'b0;
        setProfile(0, 11, 0, 11, 0, 11);

        repeat (2) @(negedge clk);
        checkOutput("reset.dutInit", 32'(dut_init), 1);
        checkOutput("reset.busy", 32'(busy), 0);
        checkOutput("reset.done", 32'(done), 0);
        checkOutput("reset.timeout", 32'(timeout), 0);
        checkOutput("reset.progIdx", 32'(prog_idx), 0);
        checkOutput("reset.lastCycles", 32'(last_cycles), 0);
        checkOutput("reset.cyclesValid", 32'(cycles_valid), 0);
        checkOutput("reset.dutReq", 32'(dut_req), 0);
        init = 1'b0;
        @(negedge clk);
        checkOutput("reset.dutInitReleased", 32'(dut_init), 0);

        // Plain latency, stale ack ignored, minimum latency.
        setProfile(0, 11, 3, 9, 0, 2);
        applyStimulus("normalStale", 1'b0);

        setProfile(0, 5, 0, 20, 0, 7);
        applyStimulus("backToBack", 1'b0);

        setProfile(0, 6, 0, 0, 0, 8);
        applyStimulus("timeoutRun", 1'b0);

        setProfile(0, 4, 1, 6, 0, 3);
        applyStimulus("afterTimeout", 1'b0);

        setProfile(0, 5, 0, 20, 0, 7);
        applyStimulus("goWhileBusy", 1'b1);

        // Reset during WAIT_ACK of program 1.
        setProfile(0, 5, 0, 20, 0, 7);
        expQ.delete();
        idxQ.delete();
        begin
            ExpEntry e;
            e.cycles = 16'd5;
            e.nextReq = 1'b1;
            expQ.push_back(e);
        end
        idxQ.push_back(0);
        idxQ.push_back(1);
        clearRunStats();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 500 && reqCount < 2; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        checkOutput("midInit.validBefore", 32'(validCount), 1);
        init = 1'b1;
        #1;
        checkOutput("midInit.dutInit", 32'(dut_init), 1);
        @(negedge clk);
        checkOutput("midInit.busy", 32'(busy), 0);
        checkOutput("midInit.lastCycles", 32'(last_cycles), 0);
        checkOutput("midInit.progIdx", 32'(prog_idx), 0);
        checkOutput("midInit.timeout", 32'(timeout), 0);
        checkOutput("midInit.dutReq", 32'(dut_req), 0);
        init = 1'b0;
        #1;
        checkOutput("midInit.dutInitReleased", 32'(dut_init), 0);
        repeat (60) @(negedge clk);
        checkOutput("midInit.noDone", 32'(doneCount), 0);
        checkOutput("midInit.staysIdle", 32'(busy), 0);
        expQ.delete();
        idxQ.delete();

        checkOutput("inv.initReqOverlap", 32'(overlapErr), 0);
        checkOutput("inv.doubleReq", 32'(doubleReqErr), 0);
        checkOutput("inv.unexpectedReq", 32'(unexpectedReq), 0);
        checkOutput("inv.unexpectedValid", 32'(unexpectedValid), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
